debug_uart_tx: RTL and testbench
================================

# debug_uart_tx

Debug-port UART transmitter that returns bytes to the host over the same pin the autobaud detector locked onto. It takes the 8-bit divisor and its write strobe from the autobaud detector, plus the selected-input index. It serializes bytes from the debug controller as 8N1 frames (configurable stop bits) on the matching one of three TX outputs. Unselected TX outputs idle high.

## Interface

Parameters:
- STOP_BITS, 1: stop-bit count per frame (1 or 2).
- PRESCALE, 32: clocks per divisor unit. One bit period is baud_div × PRESCALE clocks.

Ports:
- clk  input  1  system clock; the block uses one clock
- rst  input  1  reset, synchronous and active-high
- baud_wr  input  1  one-cycle strobe; captures baud_div
- baud_div  input  8  divisor from the autobaud detector
- rx_sel  input  2  selected pin; 0 = none, 1..3 = tx1..tx3
- tx_data  input  8  byte to send
- tx_valid  input  1  byte available
- tx_ready  output  1  block accepts a byte this cycle
- busy  output  1  frame in progress
- tx1, tx2, tx3  output  1 each  serial outputs; idle high

## Operation

- The block holds div_reg (8b), a pending divisor div_pend with a pend flag, sel_reg (2b), shift_reg (8b), bit_idx (3b), stop_cnt (1b) and a bit timer.
- FSM states: IDLE, START, DATA, STOP.
- **Divisor load:** on baud_wr, if state is IDLE, div_reg ← baud_div. Otherwise div_pend ← baud_div and pend is set. On entry to IDLE, if pend is set: div_reg ← div_pend and pend is cleared. A later baud_wr overwrites div_pend.
- **tx_ready:** tx_ready = (state==IDLE) & (div_reg≠0) & (rx_sel≠0) & ~pend.
- **Accept:** on tx_valid & tx_ready:
  - shift_reg ← tx_data; sel_reg ← rx_sel
  - bit timer cleared; bit_idx ← 0
  - state goes to START.
- **START:** the selected line drives 0 for one bit period, then state goes to DATA.
- **DATA:** the line drives shift_reg[0], LSB first. At the end of each bit period: shift right and increment bit_idx. After bit_idx 7, state goes to STOP.
- **STOP:** the line drives 1 for STOP_BITS bit periods, then state goes to IDLE.
- **Bit timer:** 13-bit counter. It ends a bit period when count == div_reg×PRESCALE−1, then wraps to 0. Multiplication by 32 is a 5-bit left shift. The timer is held at 0 in IDLE.
- **Outputs:**
  - tx[sel_reg] follows the frame.
  - The other two TX outputs are 1.
  - In IDLE, all TX outputs are 1.
  - All TX outputs are registered.
- **busy:** busy = (state≠IDLE).
- **rx_sel change mid-frame:** ignored; the frame finishes on sel_reg.
- **div_reg change mid-frame:** impossible by construction; a new divisor is deferred via pend.
- **tx_valid while not ready:** ignored; no data is captured.
- **rst mid-frame:**
  - State goes to IDLE and all TX outputs go to 1 on the next edge.
  - div_reg and div_pend are cleared to 0; pend is cleared.
  - A truncated frame is acceptable.

## Timing

- **Reset values:**
  - tx1/tx2/tx3 = 1; tx_ready = 0; busy = 0
  - div_reg = 0; sel_reg = 0; state = IDLE.
- **Latency:** an accept in cycle N puts the start bit on the line from edge N+1.
- **Bit length:** each bit is exactly div_reg×PRESCALE clocks.
- **Frame length:** (9+STOP_BITS)×div_reg×PRESCALE clocks from the first start-bit cycle to the last stop-bit cycle.
- **Back-to-back frames:** tx_ready rises in the first IDLE cycle after STOP. The minimum gap between frames is 1 clock of idle-high beyond the stop bits.
- **baud_wr coinciding with the STOP→IDLE transition:** treated as mid-frame (goes to pend). It is applied in the following cycle; tx_ready stays low that cycle.
- **baud_wr and accept in the same IDLE cycle:** the accept is allowed, and the new divisor applies to this frame. The bit timer reads div_reg starting from START.

## Structure

- **Package debug_uart_pkg:**
  - state encoding (IDLE=0, START=1, DATA=2, STOP=3)
  - PRESCALE default
  - IDLE_LEVEL = 1'b1.
- **Sub-module debug_baud_timer:**
  - inputs: clk, rst, run, div[7:0]
  - output: one-cycle bit_end pulse
  - contains the 13-bit counter and the ×PRESCALE compare.
- The FSM, shift register, divisor pend logic and output mux stay in debug_uart_tx.

## Test plan

- **Basic frame:** baud_wr with div=2 (64 clk/bit), rx_sel=1, send 0xA5.
  - tx1 is low starting one cycle after the accept, followed by 1,0,1,0,0,1,0,1 (LSB first), then high; each bit is 64 clocks.
  - tx2 and tx3 stay high throughout.
  - busy is high for exactly 640 clocks.
- **Not ready:** div=0, or rx_sel=0, with tx_valid held high.
  - tx_ready stays 0 and all TX outputs stay high.
  - After baud_wr with div=1, 0x00 is accepted and produces a frame with a 32-clock start bit.
- **Mid-frame changes:** during a 0x3C frame at div=3 on tx2, apply baud_wr div=5 and switch rx_sel to 3.
  - The frame completes on tx2 with 96-clock bits.
  - The next byte goes out on tx3 with 160-clock bits.
  - tx_ready stays low until the pend flag is applied.
- **Back-to-back:** tx_valid held high with 0x55 then 0xFF, div=1, STOP_BITS=2.
  - Both frames are correct, each 352 clocks.
  - The inter-frame idle is exactly 1 clock beyond the stop bits.
- **Reset mid-frame:** assert rst at the DATA bit 3 midpoint.
  - Next cycle: all TX outputs are 1, busy=0, tx_ready=0 (div cleared).
  - After a new baud_wr, a full clean frame is sent.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared definitions for the debug-port UART transmitter: FSM encoding,
// default prescale and the idle line level.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   PRESCALE_DEFAULT = 32;
    localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/debug_uart_tx_if.sv
// Control/data bundle between the debug controller/autobaud side and the
// UART transmitter.
interface debug_uart_tx_if;

    logic       baud_wr;
    logic [7:0] baud_div;
    logic [1:0] rx_sel;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    modport master (
        output baud_wr, baud_div, rx_sel, tx_data, tx_valid,
        input  tx_ready, busy
    );

    modport slave (
        input  baud_wr, baud_div, rx_sel, tx_data, tx_valid,
        output tx_ready, busy
    );

endinterface

// File: rtl/debug_baud_timer.sv
// Bit-period timer: counts div*PRESCALE clocks while running and pulses
// bit_end on the last clock of each bit period.
module debug_baud_timer
    import debug_uart_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] div,
    output logic       bit_end
);

    logic [12:0] count;
    logic [12:0] limit;

    // With the default prescale of 32 this is just div shifted left by 5.
    assign limit   = 13'(32'(div) * 32'(PRESCALE) - 32'd1);
    assign bit_end = run && (count == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!run || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 13'd1;
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug-port UART transmitter: sends 8N1 frames (1 or 2 stop bits) on the
// TX pin picked by the autobaud detector; unselected pins idle high.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int STOP_BITS = 1,
    parameter int PRESCALE  = PRESCALE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    debug_uart_tx_if.slave bus,
    output logic           tx1,
    output logic           tx2,
    output logic           tx3
);

    uart_state_t state, state_next;

    logic [7:0] div_reg;
    logic [7:0] div_pend;
    logic       pend;
    logic [1:0] sel_reg, sel_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_idx, idx_next;
    logic       stop_cnt, stop_next;
    logic       line_next;
    logic       bit_end;
    logic       accept;

    debug_baud_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state != IDLE),
        .div     (div_reg),
        .bit_end (bit_end)
    );

    assign bus.tx_ready = (state == IDLE) && (div_reg != 8'd0) &&
                          (bus.rx_sel != 2'd0) && !pend;
    assign bus.busy     = (state != IDLE);
    assign accept       = bus.tx_valid && bus.tx_ready;

    always_comb begin
        state_next = state;
        sel_next   = sel_reg;
        shift_next = shift_reg;
        idx_next   = bit_idx;
        stop_next  = stop_cnt;
        line_next  = IDLE_LEVEL;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_next = bus.tx_data;
                    sel_next   = bus.rx_sel;
                    idx_next   = 3'd0;
                    stop_next  = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_next = IDLE;
                    end else begin
                        stop_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is derived from the upcoming state so the registered
        // TX pins change on the same edge as the FSM.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
            default: line_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_reg   <= 2'd0;
            shift_reg <= 8'd0;
            bit_idx   <= 3'd0;
            stop_cnt  <= 1'b0;
            tx1       <= IDLE_LEVEL;
            tx2       <= IDLE_LEVEL;
            tx3       <= IDLE_LEVEL;
        end else begin
            state     <= state_next;
            sel_reg   <= sel_next;
            shift_reg <= shift_next;
            bit_idx   <= idx_next;
            stop_cnt  <= stop_next;
            tx1       <= (sel_next == 2'd1) ? line_next : IDLE_LEVEL;
            tx2       <= (sel_next == 2'd2) ? line_next : IDLE_LEVEL;
            tx3       <= (sel_next == 2'd3) ? line_next : IDLE_LEVEL;
        end
    end

    // A divisor written while a frame is running is parked in div_pend and
    // only takes effect once the FSM is back in IDLE, so bit timing never
    // changes inside a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= 8'd0;
            div_pend <= 8'd0;
            pend     <= 1'b0;
        end else if (bus.baud_wr) begin
            if (state == IDLE) begin
                div_reg <= bus.baud_div;
                pend    <= 1'b0;
            end else begin
                div_pend <= bus.baud_div;
                pend     <= 1'b1;
            end
        end else if ((state == IDLE) && pend) begin
            div_reg <= div_pend;
            pend    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: a frame monitor per DUT checks every bit of every
// frame against a queue of expected frames pushed when each byte is accepted.
module tb_debug_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         line;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   frames_done0 = 0;
    int   frames_done1 = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   start_q0[$];
    int   start_q1[$];

    logic a1, a2, a3;
    logic b1, b2, b3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_uart_tx_if bus0();
    debug_uart_tx_if bus1();

    debug_uart_tx #(.STOP_BITS(1), .PRESCALE(32)) dut (
        .clk (clk), .rst (rst), .bus (bus0), .tx1 (a1), .tx2 (a2), .tx3 (a3)
    );

    // Second instance with two stop bits, used for the back-to-back scenario.
    debug_uart_tx #(.STOP_BITS(2), .PRESCALE(32)) dut_b2b (
        .clk (clk), .rst (rst), .bus (bus1), .tx1 (b1), .tx2 (b2), .tx3 (b3)
    );

    function automatic logic [2:0] get_lines(input int which);
        return (which == 0) ? {a3, a2, a1} : {b3, b2, b1};
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 0) ? bus0.tx_ready : bus1.tx_ready;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic set_sel(input int which, input logic [1:0] s);
        if (which == 0) bus0.rx_sel = s; else bus1.rx_sel = s;
    endtask

    task automatic set_valid(input int which, input logic v);
        if (which == 0) bus0.tx_valid = v; else bus1.tx_valid = v;
    endtask

    task automatic set_div(input int which, input logic [7:0] d);
        @(posedge clk); #1;
        if (which == 0) begin bus0.baud_wr = 1'b1; bus0.baud_div = d; end
        else            begin bus1.baud_wr = 1'b1; bus1.baud_div = d; end
        @(posedge clk); #1;
        if (which == 0) bus0.baud_wr = 1'b0; else bus1.baud_wr = 1'b0;
    endtask

    // Presents a byte, waits for it to be accepted and queues the expected
    // frame. tx_valid is left high; acc is the cycle of the accepting edge.
    task automatic send_byte(input int which, input logic [7:0] d, input int line,
                             input int len, output int acc);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk); #1;
        if (which == 0) bus0.tx_data = d; else bus1.tx_data = d;
        set_valid(which, 1'b1);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (get_ready(which)) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL accept_timeout dut%0d data=%h ready never rose", which, d);
            acc = -1;
            return;
        end
        e.data = d; e.line = line; e.len = len;
        if (which == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic wait_frames(input int which, input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (((which == 0) ? frames_done0 : frames_done1) >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL frame_timeout dut%0d frames=%0d want=%0d", which,
                     (which == 0) ? frames_done0 : frames_done1, n);
        end
    endtask

    function automatic int pop_start(input int which);
        if (which == 0) return (start_q0.size() > 0) ? start_q0.pop_front() : -1;
        return (start_q1.size() > 0) ? start_q1.pop_front() : -1;
    endfunction

    // Watches one DUT's TX pins; every bit of every frame is compared cycle by
    // cycle against the expected frame at the head of the queue.
    task automatic monitor(input int which);
        exp_t       e;
        logic [2:0] l, want, got;
        int         sb;
        bit         ok, aborted, bv;
        sb = (which == 0) ? 1 : 2;
        forever begin
            @(negedge clk);
            l = get_lines(which);
            if (rst || l == 3'b111) continue;
            if (((which == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpected_frame dut%0d lines=%b want=111", which, l);
                while (get_lines(which) != 3'b111 && !rst) @(negedge clk);
                continue;
            end
            if (which == 0) begin e = exp_q0.pop_front(); start_q0.push_back(cyc); end
            else            begin e = exp_q1.pop_front(); start_q1.push_back(cyc); end
            aborted = 1'b0;
            for (int b = 0; b < 9 + sb && !aborted; b++) begin
                bv   = (b == 0) ? 1'b0 : (b <= 8) ? e.data[b-1] : 1'b1;
                want = bv ? 3'b111 : ~(3'b001 << (e.line - 1));
                ok   = 1'b1;
                got  = want;
                for (int c = 0; c < e.len; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    l = get_lines(which);
                    if (l !== want) begin ok = 1'b0; got = l; end
                end
                if (!aborted) begin
                    total++;
                    if (!ok) begin
                        bad++;
                        $display("[TB] FAIL frame_bit dut%0d data=%h bit=%0d lines=%b want=%b",
                                 which, e.data, b, got, want);
                    end
                end
            end
            if (which == 0) frames_done0++; else frames_done1++;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            total++;
            if (get_lines(w) !== 3'b111) begin
                bad++; $display("[TB] FAIL reset_lines dut%0d got=%b want=111", w, get_lines(w));
            end
            total++;
            if (get_ready(w) !== 1'b0) begin
                bad++; $display("[TB] FAIL reset_ready dut%0d got=%b want=0", w, get_ready(w));
            end
            total++;
            if (get_busy(w) !== 1'b0) begin
                bad++; $display("[TB] FAIL reset_busy dut%0d got=%b want=0", w, get_busy(w));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int acc, s, n;
        set_sel(0, 2'd1);
        set_div(0, 8'd2);
        send_byte(0, 8'hA5, 1, 64, acc);
        set_valid(0, 1'b0);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (get_busy(0)) n++; else break;
        end
        total++;
        if (n != 640) begin bad++; $display("[TB] FAIL basic_busy_len got=%0d want=640", n); end
        wait_frames(0, 1);
        s = pop_start(0);
        total++;
        if (s != acc) begin bad++; $display("[TB] FAIL basic_latency start=%0d want=%0d", s, acc); end
    endtask

    task automatic test_not_ready();
        int  acc, s, n;
        bit  ok;
        set_sel(0, 2'd1);
        set_div(0, 8'd0);
        bus0.tx_data = 8'h77;
        set_valid(0, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (get_ready(0) !== 1'b0 || get_lines(0) !== 3'b111) ok = 1'b0;
        end
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL notready_div0 ready=%b lines=%b want 0/111", get_ready(0), get_lines(0)); end
        set_sel(0, 2'd0);
        set_div(0, 8'd1);
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (get_ready(0) !== 1'b0 || get_lines(0) !== 3'b111) ok = 1'b0;
        end
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL notready_sel0 ready=%b lines=%b want 0/111", get_ready(0), get_lines(0)); end
        set_valid(0, 1'b0);
        set_sel(0, 2'd1);
        send_byte(0, 8'h00, 1, 32, acc);
        set_valid(0, 1'b0);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (get_busy(0)) n++; else break;
        end
        total++;
        if (n != 320) begin bad++; $display("[TB] FAIL notready_busy_len got=%0d want=320", n); end
        wait_frames(0, 2);
        s = pop_start(0);
        total++;
        if (s != acc) begin bad++; $display("[TB] FAIL notready_latency start=%0d want=%0d", s, acc); end
    endtask

    task automatic test_mid_frame();
        int acc, s, n;
        bit ok, early;
        set_sel(0, 2'd2);
        set_div(0, 8'd3);
        send_byte(0, 8'h3C, 2, 96, acc);
        set_valid(0, 1'b0);
        repeat (300) @(posedge clk);
        set_div(0, 8'd5);
        set_sel(0, 2'd3);
        ok = 1'b0; early = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!get_busy(0)) begin ok = 1'b1; break; end
            if (get_ready(0)) early = 1'b1;
        end
        total++;
        if (!ok || early) begin bad++; $display("[TB] FAIL mid_frame_end idle=%b ready_early=%b want 1/0", ok, early); end
        total++;
        if (get_ready(0) !== 1'b0) begin bad++; $display("[TB] FAIL pend_ready_first_idle got=%b want=0", get_ready(0)); end
        @(negedge clk);
        total++;
        if (get_ready(0) !== 1'b1) begin bad++; $display("[TB] FAIL pend_ready_after got=%b want=1", get_ready(0)); end
        wait_frames(0, 3);
        s = pop_start(0);
        total++;
        if (s != acc) begin bad++; $display("[TB] FAIL mid_latency start=%0d want=%0d", s, acc); end
        send_byte(0, 8'h5A, 3, 160, acc);
        set_valid(0, 1'b0);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (get_busy(0)) n++; else break;
        end
        total++;
        if (n != 1600) begin bad++; $display("[TB] FAIL new_div_busy_len got=%0d want=1600", n); end
        wait_frames(0, 4);
        s = pop_start(0);
        total++;
        if (s != acc) begin bad++; $display("[TB] FAIL new_div_latency start=%0d want=%0d", s, acc); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, s1, s2;
        set_sel(1, 2'd1);
        set_div(1, 8'd1);
        send_byte(1, 8'h55, 1, 32, acc1);
        send_byte(1, 8'hFF, 1, 32, acc2);
        set_valid(1, 1'b0);
        wait_frames(1, 2);
        s1 = pop_start(1);
        s2 = pop_start(1);
        total++;
        if (s1 != acc1) begin bad++; $display("[TB] FAIL b2b_latency start=%0d want=%0d", s1, acc1); end
        total++;
        if (s2 - s1 != 353) begin bad++; $display("[TB] FAIL b2b_gap got=%0d want=353", s2 - s1); end
    endtask

    task automatic test_reset_mid_frame();
        int acc, s, n;
        set_sel(0, 2'd1);
        set_div(0, 8'd2);
        send_byte(0, 8'hC3, 1, 64, acc);
        set_valid(0, 1'b0);
        repeat (4 * 64 + 31) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (get_lines(0) !== 3'b111) begin bad++; $display("[TB] FAIL rstmid_lines got=%b want=111", get_lines(0)); end
        total++;
        if (get_busy(0) !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", get_busy(0)); end
        total++;
        if (get_ready(0) !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ready got=%b want=0", get_ready(0)); end
        rst = 1'b0;
        wait_frames(0, 5);
        s = pop_start(0);
        set_div(0, 8'd2);
        send_byte(0, 8'h96, 1, 64, acc);
        set_valid(0, 1'b0);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (get_busy(0)) n++; else break;
        end
        total++;
        if (n != 640) begin bad++; $display("[TB] FAIL rstmid_clean_busy got=%0d want=640", n); end
        wait_frames(0, 6);
        s = pop_start(0);
        total++;
        if (s != acc) begin bad++; $display("[TB] FAIL rstmid_clean_latency start=%0d want=%0d", s, acc); end
    endtask

    initial begin
        bus0.baud_wr = 1'b0; bus0.baud_div = 8'd0; bus0.rx_sel = 2'd1;
        bus0.tx_data = 8'd0; bus0.tx_valid = 1'b0;
        bus1.baud_wr = 1'b0; bus1.baud_div = 8'd0; bus1.rx_sel = 2'd1;
        bus1.tx_data = 8'd0; bus1.tx_valid = 1'b0;
        $display("[TB] starting debug_uart_tx bench");
        test_reset();
        test_basic();
        test_not_ready();
        test_mid_frame();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
